dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory BRAM port between the CPU load/store path
//  (requester 0) and an auxiliary master such as the UART loader or debug
//  writer (requester 1). Byte masks and data arrive already lane-aligned.
//  One transaction is granted per cycle. Memory-side outputs are registered.
//  Each requester gets its own response channel.
// PARAMETERS
//  ADDR_WIDTH  14  word-address width presented to the BRAM
//  MAX_WAIT    8   cycles requester 1 may be refused before forced grant (>=1)
// PORTS
//  clk          in   1           single clock, all logic rising-edge
//  rst          in   1           synchronous, active-high reset
//  r0_valid     in   1           CPU request valid
//  r0_ready     out  1           CPU request accepted this cycle (combinational)
//  r0_addr      in   ADDR_WIDTH  CPU word address
//  r0_wdata     in   32          CPU lane-aligned store data
//  r0_wmask     in   4           byte write mask; 4'b0000 = read
//  r0_rvalid    out  1           CPU response strobe (reads and writes)
//  r0_rdata     out  32          CPU read data; 0 for write responses
//  r1_valid/r1_ready/r1_addr/r1_wdata/r1_wmask/r1_rvalid/r1_rdata
//               same as r0_*, auxiliary requester
//  mem_en       out  1           BRAM enable
//  mem_we       out  4           BRAM byte write enables
//  mem_addr     out  ADDR_WIDTH  BRAM word address
//  mem_din      out  32          BRAM write data
//  mem_dout     in   32          BRAM read data, valid 1 cycle after mem_en
// BEHAVIOUR
//  - Reset: all outputs 0, wait_cnt=0, rr_ptr=0, in-flight tags cleared.
//  - Grant (comb., cycle N): default fixed priority r0 > r1.
//    If r1_valid && wait_cnt==MAX_WAIT, grant r1 regardless of r0.
//    Exactly one rX_ready high when any valid is high. Both low when
//    neither is valid.
//  - wait_cnt: +1 each cycle r1_valid && !r1_ready. Saturates at MAX_WAIT.
//    Clears when r1 is granted or r1_valid is low.
//  - Issue (edge N->N+1): mem_en=1, mem_we=granted wmask, mem_addr/din from
//    the granted requester. Registers tag={valid,id,is_read}.
//    With no grant: mem_en=0, mem_we=0; addr/din hold their last value.
//  - Response (edge N+1->N+2): rX_rvalid=1 for one cycle for tagged id.
//    rX_rdata=mem_dout if read, else 0. Non-tagged port: rvalid=0, rdata holds.
//  - Total latency accept->rvalid = 2 cycles. Throughput 1 req/cycle.
//    Back-to-back accepts across ports are legal; responses keep issue order.
//  - Requester must hold addr/wdata/wmask stable while valid && !ready.
//    Dropping valid before ready is permitted (request withdrawn, no effect).
//  - Reset mid-operation: issue and response stages are flushed.
//    No rvalid fires for a request accepted in the cycle reset is high or
//    the cycle before.
//  - Pipeline state: IDLE (no tag), ISSUED (tag in issue stage),
//    RESP (tag in response stage). Both stages may be occupied at once.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: round-robin. rr_ptr names the preferred port.
//    On contention the preferred port is granted, then rr_ptr flips to the
//    other port. rr_ptr is unchanged without contention. wait_cnt logic is
//    still present but can never reach MAX_WAIT>=2 under contention.
//  DMEM_ARB_RR_EN undefined: fixed priority r0 > r1 plus the MAX_WAIT
//    starvation override; rr_ptr is not instantiated.
// TESTING
//  1 r0 write addr=0x10 wdata=0xDEADBEEF wmask=4'b1111, then read 0x10 ->
//    mem_we=4'hF one cycle after accept; read r0_rdata=0xDEADBEEF 2 cycles after.
//  2 r1 alone, byte write 0x20 wmask=4'b0100 wdata=0x00AB0000, then read ->
//    r1_rvalid at N+2 with 0 data, read returns byte2=0xAB; r0_rvalid never set.
//  3 Fixed priority: r0_valid and r1_valid held high ->
//    r1_ready first high in cycle MAX_WAIT (cycle 8 from start), then r0
//    regains grant; wait_cnt back to 0.
//  4 DMEM_ARB_RR_EN: both valid for 6 cycles -> grants alternate r0,r1,r0,...
//    Responses arrive in the same order, 2 cycles later.
//  5 Reset mid-operation: accept r0 read at cycle N, assert rst in cycle N+1 ->
//    no r0_rvalid at N+2; all outputs 0 after reset.
//  6 Withdraw: r1_valid high 3 cycles under r0 contention, then low ->
//    wait_cnt returns to 0, no r1 transaction on mem_en.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory BRAM port between the CPU (r0) and an aux master (r1).
// Fixed priority r0 > r1 with a starvation override by default; define DMEM_ARB_RR_EN for round-robin.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [31:0]           r0_wdata,
    input  logic [3:0]            r0_wmask,
    output logic                  r0_rvalid,
    output logic [31:0]           r0_rdata,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [31:0]           r1_wdata,
    input  logic [3:0]            r1_wmask,
    output logic                  r1_rvalid,
    output logic [31:0]           r1_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);
    localparam int             WCW        = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    logic [WCW-1:0]        r_wait_cnt;

    // Pipeline occupancy: r_iss_valid marks ISSUED, r_rX_rvalid marks RESP; both may be set.
    logic                  r_iss_valid;
    logic                  r_iss_id;
    logic                  r_iss_rd;
    logic [3:0]            r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_din;

    logic                  r_r0_rvalid;
    logic                  r_r1_rvalid;
    logic                  r_resp_rd;
    logic [31:0]           r_r0_rdata;
    logic [31:0]           r_r1_rdata;

    logic                  w_force1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [31:0]           w_sel_wdata;
    logic [3:0]            w_sel_wmask;

`ifdef DMEM_ARB_RR_EN
    logic                  r_rr_ptr;
    logic                  w_contend;
`endif

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        w_force1 = r1_valid && (r_wait_cnt == WAIT_LIMIT);
`ifdef DMEM_ARB_RR_EN
        w_contend = r0_valid && r1_valid;
        w_gnt1    = !rst && r1_valid && (w_force1 || !r0_valid || r_rr_ptr);
`else
        w_gnt1    = !rst && r1_valid && (w_force1 || !r0_valid);
`endif
        w_gnt0      = !rst && r0_valid && !w_gnt1;
        w_any       = w_gnt0 || w_gnt1;
        w_sel_addr  = w_gnt1 ? r1_addr  : r0_addr;
        w_sel_wdata = w_gnt1 ? r1_wdata : r0_wdata;
        w_sel_wmask = w_gnt1 ? r1_wmask : r0_wmask;
    end

    // BRAM data arrives in the response cycle, so read data is steered straight from mem_dout
    // and captured into the hold register for the cycles when this port has no response.
    always_comb begin
        r0_rdata = r_r0_rdata;
        r1_rdata = r_r1_rdata;
        if (r_r0_rvalid) r0_rdata = r_resp_rd ? mem_dout : 32'h0;
        if (r_r1_rvalid) r1_rdata = r_resp_rd ? mem_dout : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_iss_valid <= 1'b0;
            r_iss_id    <= 1'b0;
            r_iss_rd    <= 1'b0;
            r_mem_we    <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_din   <= 32'h0;
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
            r_resp_rd   <= 1'b0;
            r_r0_rdata  <= 32'h0;
            r_r1_rdata  <= 32'h0;
`ifdef DMEM_ARB_RR_EN
            r_rr_ptr    <= 1'b0;
`endif
        end else begin
            r_iss_valid <= w_any;
            r_iss_id    <= w_gnt1;
            r_iss_rd    <= (w_sel_wmask == 4'h0);
            r_mem_we    <= w_any ? w_sel_wmask : 4'h0;
            if (w_any) begin
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_wdata;
            end

            r_r0_rvalid <= r_iss_valid && !r_iss_id;
            r_r1_rvalid <= r_iss_valid && r_iss_id;
            r_resp_rd   <= r_iss_rd;
            r_r0_rdata  <= r0_rdata;
            r_r1_rdata  <= r1_rdata;

            if (!r1_valid || w_gnt1) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
`ifdef DMEM_ARB_RR_EN
            if (w_contend) r_rr_ptr <= !w_gnt1;
`endif
        end
    end

    assign r0_ready  = w_gnt0;
    assign r1_ready  = w_gnt1;
    assign r0_rvalid = r_r0_rvalid;
    assign r1_rvalid = r_r1_rvalid;
    assign mem_en    = r_iss_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table, directed corner sequences and a randomized run against
// a transaction-level reference model, with a behavioural BRAM attached to the memory port.
module tb_dmem_port_arbiter;
    localparam int AW       = 14;
    localparam int MAX_WAIT = 8;
    localparam int N_RAND   = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_valid = 1'b0, r1_valid = 1'b0;
    logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [31:0]   r0_wdata = '0, r1_wdata = '0;
    logic [3:0]    r0_wmask = '0, r1_wmask = '0;
    logic [31:0]   r0_rdata, r1_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout = '0;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wmask(r0_wmask), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wmask(r1_wmask), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with one-cycle read latency.
    bit [31:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= bram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input bit port, input bit v, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        if (!port) begin
            r0_valid = v; r0_addr = a; r0_wdata = d; r0_wmask = m;
        end else begin
            r1_valid = v; r1_addr = a; r1_wdata = d; r1_wmask = m;
        end
    endtask

    function automatic logic get_ready(input bit p);
        return p ? r1_ready : r0_ready;
    endfunction

    function automatic logic get_rvalid(input bit p);
        return p ? r1_rvalid : r0_rvalid;
    endfunction

    function automatic logic [31:0] get_rdata(input bit p);
        return p ? r1_rdata : r0_rdata;
    endfunction

    task automatic idle();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1; idle();
        tick();
        tick(); rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " r0_ready"},  32'(r0_ready),  32'd0);
        check({tag, " r1_ready"},  32'(r1_ready),  32'd0);
        check({tag, " r0_rvalid"}, 32'(r0_rvalid), 32'd0);
        check({tag, " r1_rvalid"}, 32'(r1_rvalid), 32'd0);
        check({tag, " r0_rdata"},  r0_rdata,       32'd0);
        check({tag, " r1_rdata"},  r1_rdata,       32'd0);
        check({tag, " mem_en"},    32'(mem_en),    32'd0);
        check({tag, " mem_we"},    32'(mem_we),    32'd0);
        check({tag, " mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, " mem_din"},   mem_din,        32'd0);
    endtask

    // One isolated transaction: accept at N, memory issue at N+1, response at N+2.
    task automatic do_single(input string tag, input bit p, input logic [AW-1:0] a,
                             input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp_rd);
        tick(); drive(p, 1'b1, a, d, m);
        sample();
        check({tag, " ready"},       32'(get_ready(p)),  32'd1);
        check({tag, " other ready"}, 32'(get_ready(!p)), 32'd0);
        tick(); idle();
        sample();
        check({tag, " mem_en"},   32'(mem_en),   32'd1);
        check({tag, " mem_we"},   32'(mem_we),   32'(m));
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
        check({tag, " mem_din"},  mem_din,       d);
        check({tag, " early rvalid"}, 32'(r0_rvalid | r1_rvalid), 32'd0);
        tick();
        sample();
        check({tag, " rvalid"},       32'(get_rvalid(p)),  32'd1);
        check({tag, " other rvalid"}, 32'(get_rvalid(!p)), 32'd0);
        check({tag, " rdata"},        get_rdata(p),        exp_rd);
        check({tag, " mem_en idle"},  32'(mem_en),         32'd0);
    endtask

    typedef struct {
        bit            port;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        logic [31:0]   exp_rdata;
    } vec_t;

    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } resp_t;

    initial begin
        vec_t        vecs[8];
        resp_t       q[$];
        bit [31:0]   shadow[16];
        bit          pv[2];
        bit          acc[2];
        logic [AW-1:0] pa[2];
        logic [31:0] pd[2];
        logic [3:0]  pm[2];
        int          streak, g, prev_g, idx;
        bit          pref;
        logic [AW-1:0] prev_a;
        logic [31:0] prev_d;
        logic [3:0]  prev_m;

        vecs[0] = '{1'b0, 14'h10, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 14'h10, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 14'h20, 32'h00AB0000, 4'h4, 32'h0};
        vecs[3] = '{1'b1, 14'h20, 32'h0,        4'h0, 32'h00AB0000};
        vecs[4] = '{1'b0, 14'h11, 32'h12345678, 4'h3, 32'h0};
        vecs[5] = '{1'b0, 14'h11, 32'h0,        4'h0, 32'h00005678};
        vecs[6] = '{1'b1, 14'h10, 32'h000000FF, 4'h1, 32'h0};
        vecs[7] = '{1'b1, 14'h10, 32'h0,        4'h0, 32'hDEADBEFF};

        do_reset();
        sample();
        check_all_zero("reset");

        for (int i = 0; i < 8; i++)
            do_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].addr, vecs[i].wdata,
                      vecs[i].wmask, vecs[i].exp_rdata);

`ifdef DMEM_ARB_RR_EN
        // Round-robin: sustained contention alternates grants, responses follow in order.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 6) begin
                drive(1'b0, 1'b1, 14'h10, 32'h0, 4'h0);
                drive(1'b1, 1'b1, 14'h20, 32'h0, 4'h0);
            end else idle();
            sample();
            if (k < 6) begin
                check($sformatf("rr k%0d r0_ready", k), 32'(r0_ready), 32'(k % 2 == 0));
                check($sformatf("rr k%0d r1_ready", k), 32'(r1_ready), 32'(k % 2 == 1));
            end
            if (k >= 2) begin
                check($sformatf("rr k%0d r0_rvalid", k), 32'(r0_rvalid), 32'(k % 2 == 0));
                check($sformatf("rr k%0d r1_rvalid", k), 32'(r1_rvalid), 32'(k % 2 == 1));
                if (k % 2 == 0) check($sformatf("rr k%0d r0_rdata", k), r0_rdata, 32'hDEADBEFF);
                else            check($sformatf("rr k%0d r1_rdata", k), r1_rdata, 32'h00AB0000);
            end
        end
`else
        // Fixed priority: r1 is forced through once it has been refused MAX_WAIT cycles.
        for (int k = 0; k < 12; k++) begin
            tick();
            drive(1'b0, 1'b1, 14'h30, 32'h0, 4'h0);
            drive(1'b1, 1'b1, 14'h31, 32'h0, 4'h0);
            sample();
            check($sformatf("starve k%0d r0_ready", k), 32'(r0_ready), 32'(k != MAX_WAIT));
            check($sformatf("starve k%0d r1_ready", k), 32'(r1_ready), 32'(k == MAX_WAIT));
        end
        tick(); idle(); tick(); tick();

        // Withdraw: a refused r1 request that drops valid leaves no trace.
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(1'b0, 1'b1, 14'h30, 32'h0, 4'h0);
            drive(1'b1, k < 3, 14'h21, 32'h0, 4'h0);
            sample();
            check($sformatf("withdraw k%0d r1_ready", k),  32'(r1_ready),  32'd0);
            check($sformatf("withdraw k%0d r1_rvalid", k), 32'(r1_rvalid), 32'd0);
        end
        for (int k = 0; k <= MAX_WAIT; k++) begin
            tick();
            drive(1'b0, 1'b1, 14'h30, 32'h0, 4'h0);
            drive(1'b1, 1'b1, 14'h21, 32'h0, 4'h0);
            sample();
            check($sformatf("rewait k%0d r1_ready", k), 32'(r1_ready), 32'(k == MAX_WAIT));
            if (k < 3) check($sformatf("rewait k%0d r1_rvalid", k), 32'(r1_rvalid), 32'd0);
        end
        tick(); idle(); tick(); tick();
`endif

        // Reset one cycle after accept flushes the in-flight read.
        tick(); drive(1'b0, 1'b1, 14'h10, 32'h0, 4'h0);
        sample();
        check("flush accept", 32'(r0_ready), 32'd1);
        tick(); idle(); rst = 1'b1;
        sample();
        check("flush issued", 32'(mem_en), 32'd1);
        tick(); rst = 1'b0;
        sample();
        check_all_zero("flush");
        tick();
        sample();
        check("flush late rvalid", 32'(r0_rvalid), 32'd0);

        // Randomized traffic against the transaction-level model.
        do_reset();
        q.delete();
        streak = 0; pref = 1'b0; prev_g = -1;
        prev_a = '0; prev_d = '0; prev_m = '0;
        pv = '{1'b0, 1'b0}; acc = '{1'b0, 1'b0};
        for (int c = 0; c < N_RAND; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (pv[p] && !acc[p]) begin
                    if ($urandom_range(0, 7) == 0 || c >= N_RAND - 3) pv[p] = 1'b0;
                end else begin
                    pv[p] = (c < N_RAND - 3) && ($urandom_range(0, 99) < (p == 0 ? 75 : 55));
                    pa[p] = 14'h200 + 14'($urandom_range(0, 15));
                    pd[p] = $urandom;
                    pm[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
                drive(p[0], pv[p], pa[p], pd[p], pm[p]);
            end
            sample();

            if (pv[1] && streak == MAX_WAIT) g = 1;
`ifdef DMEM_ARB_RR_EN
            else if (pv[0] && pv[1])        g = int'(pref);
`else
            else if (pv[0] && pv[1])        g = 0;
`endif
            else if (pv[0])                 g = 0;
            else if (pv[1])                 g = 1;
            else                            g = -1;

            check($sformatf("rand c%0d r0_ready", c), 32'(r0_ready), 32'(g == 0));
            check($sformatf("rand c%0d r1_ready", c), 32'(r1_ready), 32'(g == 1));
            check($sformatf("rand c%0d mem_en", c),   32'(mem_en),   32'(prev_g >= 0));
            if (prev_g >= 0) begin
                check($sformatf("rand c%0d mem_we", c),   32'(mem_we),   32'(prev_m));
                check($sformatf("rand c%0d mem_addr", c), 32'(mem_addr), 32'(prev_a));
                check($sformatf("rand c%0d mem_din", c),  mem_din,       prev_d);
            end
            if (q.size() > 0 && q[0].due == c) begin
                check($sformatf("rand c%0d r0_rvalid", c), 32'(r0_rvalid), 32'(!q[0].id));
                check($sformatf("rand c%0d r1_rvalid", c), 32'(r1_rvalid), 32'(q[0].id));
                check($sformatf("rand c%0d rdata", c), get_rdata(q[0].id), q[0].data);
                void'(q.pop_front());
            end else begin
                check($sformatf("rand c%0d r0_rvalid", c), 32'(r0_rvalid), 32'd0);
                check($sformatf("rand c%0d r1_rvalid", c), 32'(r1_rvalid), 32'd0);
            end

            if (pv[1] && g != 1) streak = (streak < MAX_WAIT) ? streak + 1 : streak;
            else                 streak = 0;
`ifdef DMEM_ARB_RR_EN
            if (pv[0] && pv[1]) pref = (g == 0);
`endif
            if (g >= 0) begin
                idx = int'(pa[g]) - 'h200;
                q.push_back('{c + 2, g[0], (pm[g] == 4'h0) ? shadow[idx] : 32'h0});
                for (int b = 0; b < 4; b++)
                    if (pm[g][b]) shadow[idx][8*b +: 8] = pd[g][8*b +: 8];
                prev_a = pa[g]; prev_d = pd[g]; prev_m = pm[g];
            end
            acc[0] = (g == 0);
            acc[1] = (g == 1);
            prev_g = g;
        end
        check("rand drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
